// File: rtl/pipeline_ingress_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ingress_scheduler_if
// Description : Requester-side and pipeline-side handshake bundle of the
//               ingress scheduler. The "master" view belongs to the
//               scheduler; the "slave" view belongs to its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_ingress_scheduler_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 512
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ*2-1:0]          req_priority;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          out_valid;
  logic [DATA_WIDTH-1:0]         out_data;
  logic [IDX_W-1:0]              out_src;
  logic                          out_ready;

  modport master (
    input  req_valid, req_data, req_priority, out_ready,
    output req_ready, out_valid, out_data, out_src
  );

  modport slave (
    output req_valid, req_data, req_priority, out_ready,
    input  req_ready, out_valid, out_data, out_src
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_ingress_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ingress_scheduler
// Description : Strict-priority, credit-weighted round-robin arbiter feeding
//               a one-deep output register, with grant/stall statistics and
//               a sticky starvation alarm.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ingress_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 512,
  parameter int WEIGHT_WIDTH = 4,
  parameter int STARVE_LIMIT = 64
) (
  input  wire                            clk,
  input  wire                            rst_n,
  input  wire                            enable,
  pipeline_ingress_scheduler_if.master   bus,
  input  wire [NUM_REQ*WEIGHT_WIDTH-1:0] weight_cfg,
  input  wire                            cfg_load,
  output logic [31:0]                    granted_packets,
  output logic [31:0]                    stall_cycles,
  output logic                           starve_flag,
  output logic [$clog2(NUM_REQ)-1:0]     starve_src
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [0:0] {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [IDX_W-1:0]        out_src_q, out_src_d;
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [WEIGHT_WIDTH-1:0] credit_q [NUM_REQ];
  logic [WEIGHT_WIDTH-1:0] credit_d [NUM_REQ];
  logic [WEIGHT_WIDTH-1:0] weight_q [NUM_REQ];
  logic [WEIGHT_WIDTH-1:0] weight_d [NUM_REQ];
  logic [CNT_W-1:0]        wait_q [NUM_REQ];
  logic [CNT_W-1:0]        wait_d [NUM_REQ];
  logic [31:0]             granted_q, granted_d;
  logic [31:0]             stall_q, stall_d;
  logic                    starve_flag_q, starve_flag_d;
  logic [IDX_W-1:0]        starve_src_q, starve_src_d;

  logic [1:0]              top_lvl;
  logic [NUM_REQ-1:0]      at_lvl, elig, cand;
  logic                    reload_all, grant_ok, grant, found;
  logic [IDX_W-1:0]        grant_idx;
  logic                    starve_hit;
  logic [IDX_W-1:0]        starve_hit_src;

  // Arbitration: top priority level, credit eligibility, rotating search, grant.
  always_comb begin
    top_lvl = 2'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.req_valid[i] && (bus.req_priority[i*2 +: 2] > top_lvl)) begin
        top_lvl = bus.req_priority[i*2 +: 2];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      at_lvl[i] = bus.req_valid[i] && (bus.req_priority[i*2 +: 2] == top_lvl);
      elig[i]   = at_lvl[i] && (credit_q[i] != '0);
    end
    // Level exhausted its credits: arbitrate on the whole level, reload at the edge.
    reload_all = (elig == '0) && (at_lvl != '0);
    cand       = reload_all ? at_lvl : elig;
    found      = 1'b0;
    grant_idx  = '0;
    // First pass: indices above rr_ptr; second pass wraps around from index 0.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && cand[i] && (IDX_W'(i) > rr_ptr_q)) begin
        found     = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && cand[i]) begin
        found     = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
    grant_ok = enable && !cfg_load && ((state_q == S_EMPTY) || bus.out_ready);
    grant    = grant_ok && found;
    bus.req_ready = '0;
    if (grant) begin
      bus.req_ready[grant_idx] = 1'b1;
    end
  end

  // Next state for the output stage, credits, weights and statistics.
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_src_d  = out_src_q;
    rr_ptr_d   = rr_ptr_q;
    credit_d   = credit_q;
    weight_d   = weight_q;
    granted_d  = granted_q + {31'd0, grant};
    stall_d    = stall_q + {31'd0, (state_q == S_FULL) && !bus.out_ready};

    case (state_q)
      S_EMPTY: if (grant) state_d = S_FULL;
      S_FULL:  if (bus.out_ready && !grant) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase

    if (grant) begin
      out_data_d = bus.req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
      out_src_d  = grant_idx;
      rr_ptr_d   = grant_idx;
    end

    if (cfg_load) begin
      // A zero weight would lock a requester out forever, so it counts as one.
      for (int i = 0; i < NUM_REQ; i++) begin
        weight_d[i] = (weight_cfg[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] == '0) ?
                      WEIGHT_WIDTH'(1) : weight_cfg[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        credit_d[i] = weight_d[i];
      end
    end else if (grant) begin
      if (reload_all) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          credit_d[i] = weight_q[i];
        end
      end
      credit_d[grant_idx] = (reload_all ? weight_q[grant_idx] : credit_q[grant_idx])
                            - WEIGHT_WIDTH'(1);
    end
  end

  // Wait counters and the sticky starvation alarm with first-offender capture.
  always_comb begin
    starve_flag_d  = starve_flag_q;
    starve_src_d   = starve_src_q;
    starve_hit     = 1'b0;
    starve_hit_src = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.req_valid[i] && !bus.req_ready[i]) begin
        wait_d[i] = (wait_q[i] == STARVE_MAX) ? wait_q[i] : wait_q[i] + CNT_W'(1);
      end else begin
        wait_d[i] = '0;
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (wait_d[i] == STARVE_MAX) begin
        starve_hit     = 1'b1;
        starve_hit_src = IDX_W'(i);
      end
    end
    if (!starve_flag_q && starve_hit) begin
      starve_flag_d = 1'b1;
      starve_src_d  = starve_hit_src;
    end
  end

  // State register; reset discards any held beat and restores unit weights.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_EMPTY;
      out_data_q    <= '0;
      out_src_q     <= '0;
      rr_ptr_q      <= IDX_W'(NUM_REQ - 1);
      granted_q     <= '0;
      stall_q       <= '0;
      starve_flag_q <= 1'b0;
      starve_src_q  <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        credit_q[i] <= WEIGHT_WIDTH'(1);
        weight_q[i] <= WEIGHT_WIDTH'(1);
        wait_q[i]   <= '0;
      end
    end else begin
      state_q       <= state_d;
      out_data_q    <= out_data_d;
      out_src_q     <= out_src_d;
      rr_ptr_q      <= rr_ptr_d;
      granted_q     <= granted_d;
      stall_q       <= stall_d;
      starve_flag_q <= starve_flag_d;
      starve_src_q  <= starve_src_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        credit_q[i] <= credit_d[i];
        weight_q[i] <= weight_d[i];
        wait_q[i]   <= wait_d[i];
      end
    end
  end

  assign bus.out_valid   = (state_q == S_FULL);
  assign bus.out_data    = out_data_q;
  assign bus.out_src     = out_src_q;
  assign granted_packets = granted_q;
  assign stall_cycles    = stall_q;
  assign starve_flag     = starve_flag_q;
  assign starve_src      = starve_src_q;
endmodule
`default_nettype wire

// File: tb/tb_pipeline_ingress_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ingress_scheduler
// Description : Directed and randomized bench for the ingress scheduler,
//               compared every cycle against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ingress_scheduler;
  localparam int N  = 4;
  localparam int DW = 512;
  localparam int WW = 4;
  localparam int SL = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b1;
  logic          cfg_load = 1'b0;
  logic [N*WW-1:0] weight_cfg = '0;
  logic [31:0]   granted_packets, stall_cycles;
  logic          starve_flag;
  logic [1:0]    starve_src;

  pipeline_ingress_scheduler_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

  pipeline_ingress_scheduler #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .STARVE_LIMIT(SL)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable          (enable),
    .bus             (bus),
    .weight_cfg      (weight_cfg),
    .cfg_load        (cfg_load),
    .granted_packets (granted_packets),
    .stall_cycles    (stall_cycles),
    .starve_flag     (starve_flag),
    .starve_src      (starve_src)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          m_weight [N];
  int          m_credit [N];
  int          m_wait   [N];
  int          m_rr;
  bit          m_full;
  logic [DW-1:0] m_data;
  int          m_src;
  logic [31:0] m_gp, m_stall;
  bit          m_flag;
  int          m_fsrc;
  int          last_grant;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_weight[i] = 1;
      m_credit[i] = 1;
      m_wait[i]   = 0;
    end
    m_rr = N - 1; m_full = 0; m_data = '0; m_src = 0;
    m_gp = '0; m_stall = '0; m_flag = 0; m_fsrc = 0; last_grant = -1;
  endtask

  task automatic randomize_data();
    for (int w = 0; w < N*DW/32; w++) bus.req_data[w*32 +: 32] = $urandom;
  endtask

  // One clock cycle: check mid-cycle against the model, then advance the model at the edge.
  task automatic step();
    int top, g, best, d;
    bit any_el, use_lvl, allowed, grant;
    bit at_l [N];
    bit el   [N];
    logic [DW-1:0] gdata;
    logic [N-1:0]  exp_ready;
    #3;
    top = -1;
    for (int i = 0; i < N; i++)
      if (bus.req_valid[i] && int'(bus.req_priority[i*2 +: 2]) > top) top = int'(bus.req_priority[i*2 +: 2]);
    any_el = 0;
    for (int i = 0; i < N; i++) begin
      at_l[i] = bus.req_valid[i] && (int'(bus.req_priority[i*2 +: 2]) == top);
      el[i]   = at_l[i] && (m_credit[i] > 0);
      if (el[i]) any_el = 1;
    end
    use_lvl = !any_el;
    g = -1; best = N;
    for (int i = 0; i < N; i++) begin
      if (use_lvl ? at_l[i] : el[i]) begin
        d = (i - m_rr - 1 + 2*N) % N;
        if (d < best) begin best = d; g = i; end
      end
    end
    allowed = enable && !cfg_load && (!m_full || bus.out_ready);
    grant = allowed && (g >= 0);
    exp_ready = '0;
    if (grant) exp_ready[g] = 1'b1;
    gdata = grant ? bus.req_data[g*DW +: DW] : '0;

    chk("req_ready", bus.req_ready, exp_ready);
    chk("out_valid", bus.out_valid, m_full);
    chk("out_data", bus.out_data, m_data);
    chk("out_src", bus.out_src, m_src);
    chk("granted_packets", granted_packets, m_gp);
    chk("stall_cycles", stall_cycles, m_stall);
    chk("starve_flag", starve_flag, m_flag);
    chk("starve_src", starve_src, m_fsrc);

    @(posedge clk);
    if (cfg_load) begin
      for (int i = 0; i < N; i++) begin
        m_weight[i] = (weight_cfg[i*WW +: WW] == 0) ? 1 : int'(weight_cfg[i*WW +: WW]);
        m_credit[i] = m_weight[i];
      end
    end else if (grant) begin
      if (use_lvl) for (int i = 0; i < N; i++) m_credit[i] = m_weight[i];
      m_credit[g] = m_credit[g] - 1;
      m_rr = g;
    end
    if (m_full && !bus.out_ready) m_stall = m_stall + 1;
    if (grant) m_gp = m_gp + 1;
    if (grant) begin
      m_full = 1; m_data = gdata; m_src = g;
    end else if (m_full && bus.out_ready) begin
      m_full = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (bus.req_valid[i] && !(grant && g == i)) m_wait[i] = (m_wait[i] < SL) ? m_wait[i] + 1 : SL;
      else m_wait[i] = 0;
    end
    if (!m_flag) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (m_wait[i] == SL) begin m_flag = 1; m_fsrc = i; end
      end
    end
    last_grant = grant ? g : -1;
    #1;
  endtask

  initial begin
    int cnt [N];
    logic [DW-1:0] hold_data;
    logic [31:0]   s0;

    bus.req_valid = '0; bus.req_priority = '0; bus.req_data = '0; bus.out_ready = 1'b1;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_data", bus.out_data, '0);
    chk("rst_out_src", bus.out_src, '0);
    chk("rst_granted", granted_packets, '0);
    chk("rst_stall", stall_cycles, '0);
    chk("rst_starve", starve_flag, 1'b0);
    rst_n = 1'b1;

    // Equal priority, unit weights: plain round robin starting at index 0.
    bus.req_valid = 4'hF; bus.req_priority = 8'h55;
    for (int k = 0; k < 8; k++) begin
      randomize_data();
      step();
      chk("t1_order", last_grant, k % N);
    end
    chk("t1_granted_8", granted_packets, 32'd8);

    // Weights {3,1,1,1}: requester 0 gets three of every six grants.
    weight_cfg = 16'h1113; cfg_load = 1'b1;
    step();
    chk("t2_no_grant_on_cfg", last_grant, -1);
    cfg_load = 1'b0; weight_cfg = '0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int k = 0; k < 6; k++) begin
      randomize_data();
      step();
      if (last_grant >= 0) cnt[last_grant]++;
    end
    chk("t2_cnt0", cnt[0], 3);
    chk("t2_cnt1", cnt[1], 1);
    chk("t2_cnt2", cnt[2], 1);
    chk("t2_cnt3", cnt[3], 1);

    // Requester 2 alone at top priority starves the rest.
    bus.req_valid = '0;
    step();
    bus.req_valid = 4'hF; bus.req_priority = 8'h30;
    for (int k = 0; k < SL - 1; k++) begin
      randomize_data();
      step();
    end
    chk("t3_flag_before_limit", starve_flag, 1'b0);
    step();
    chk("t3_flag_at_limit", starve_flag, 1'b1);
    chk("t3_src_at_limit", starve_src, 2'd0);

    // Back-pressure for ten cycles while FULL.
    bus.req_priority = 8'h55;
    randomize_data();
    step();
    hold_data = bus.out_data;
    s0 = stall_cycles;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      randomize_data();
      step();
    end
    chk("t4_data_held", bus.out_data, hold_data);
    chk("t4_stall_10", stall_cycles - s0, 32'd10);
    bus.out_ready = 1'b1;
    step();
    chk("t4_regrant", last_grant >= 0, 1'b1);

    // enable low drains the held beat without new grants.
    enable = 1'b0;
    step();
    chk("t5_drained", bus.out_valid, 1'b0);
    step();
    enable = 1'b1;
    step();
    chk("t5_resumed", bus.out_valid, 1'b1);

    // Randomized traffic.
    for (int k = 0; k < 300; k++) begin
      bus.req_valid    = 4'($urandom);
      bus.req_priority = 8'($urandom);
      bus.out_ready    = ($urandom_range(0, 9) < 7);
      enable           = ($urandom_range(0, 9) < 9);
      cfg_load         = ($urandom_range(0, 19) == 0);
      weight_cfg       = 16'($urandom);
      randomize_data();
      step();
    end
    enable = 1'b1; cfg_load = 1'b0; bus.out_ready = 1'b1;

    // Asynchronous reset while FULL.
    bus.req_valid = 4'hF; bus.req_priority = 8'h55;
    randomize_data();
    step();
    chk("t6_full_before_rst", bus.out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_out_valid", bus.out_valid, 1'b0);
    chk("t6_rst_out_data", bus.out_data, '0);
    chk("t6_rst_granted", granted_packets, '0);
    chk("t6_rst_stall", stall_cycles, '0);
    chk("t6_rst_starve", starve_flag, 1'b0);
    m_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      randomize_data();
      step();
      chk("t6_order_after_rst", last_grant, k % N);
    end
    for (int k = 0; k < 100; k++) begin
      bus.req_valid    = 4'($urandom);
      bus.req_priority = 8'($urandom);
      bus.out_ready    = ($urandom_range(0, 9) < 6);
      enable           = ($urandom_range(0, 9) < 9);
      cfg_load         = ($urandom_range(0, 19) == 0);
      weight_cfg       = 16'($urandom);
      randomize_data();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
